dcm_multi: RTL and testbench
============================

// Module: dcm_multi
// PURPOSE
//   Multi-channel programmable clock divider; successor to the single-output DCM.
//   Generates NUM_CH divided clock-enable-style square waves from the system clock.
//   Each channel has its own rate select and enable, written through a valid/ready
//   config port. Updates apply only at a period boundary, so outputs never glitch.
//   Sits between the board clock and the display/counter blocks that need slow clocks.
// PARAMETERS
//   NUM_CH     2          number of output channels (1..8)
//   BASE_COUNT 5_000_000  half-period in system cycles at multiplier 1
//   CNT_W      30         counter width; must hold BASE_COUNT*128-1
//   RESET_EN   1          channel enable value after reset (applies to all channels)
// PORTS
//   clock      in   1          system clock, all logic on rising edge
//   reset      in   1          asynchronous, active-high
//   cfg_valid  in   1          config write request
//   cfg_ready  out  1          config write can be accepted (combinational)
//   cfg_ch     in   3          target channel index
//   cfg_sel    in   3          rate select 0..7
//   cfg_en     in   1          channel enable
//   cfg_err    out  1          1-cycle pulse: accepted write had cfg_ch >= NUM_CH
//   clk_out    out  NUM_CH     divided outputs, one bit per channel
//   sel_out    out  3*NUM_CH   active rate select per channel, ch0 in [2:0]
//   pending    out  NUM_CH     channel has a shadowed update not yet applied
// BEHAVIOUR
//   Reset: clk_out=0, cnt=0, sel_out=0, en=RESET_EN, pending=0, cfg_err=0, shadows=0.
//   Rate table sel->mult: 0:1 1:2 2:4 3:10 4:16 5:32 6:64 7:128.
//   half = BASE_COUNT*mult, computed in CNT_W bits. Full period = 2*half cycles.
//   Running channel (en=1), per cycle:
//     cnt==half-1 -> cnt<=0, clk_out toggles; else cnt<=cnt+1.
//     First rising edge of clk_out occurs half cycles after reset release.
//   Disabled channel: cnt held 0, clk_out held 0.
//   Handshake: a write is accepted when cfg_valid && cfg_ready.
//     cfg_ready = 1 if cfg_ch >= NUM_CH, else ~pending[cfg_ch].
//     Accepted, valid channel: shadow<= {cfg_en,cfg_sel}, pending[ch]<=1 next cycle.
//     Accepted, cfg_ch >= NUM_CH: data dropped, cfg_err=1 for exactly one cycle.
//   Boundary: running channel with cnt==half-1 and clk_out==1 (the falling toggle).
//   Apply rule, for a channel with pending=1:
//     Running: at the boundary, load sel/en from shadow, cnt<=0, clk_out<=0, clear
//       pending. If the new en=0, clk_out then stays 0.
//     Disabled: apply on the first cycle pending is seen (next cycle after accept).
//       If the new en=1, counting starts from cnt=0 with clk_out=0.
//   A write accepted in the same cycle as a boundary is not applied at that
//     boundary; it waits for the following boundary.
//   Writes to a channel whose pending=1 stall (cfg_ready=0) until it is applied.
//   Other channels are unaffected by a write to one channel.
//   Same-value write: still waits for a boundary and restarts nothing visible.
//   Counters never exceed half-1. If sel changes, the new half is used only
//     after the reload at the boundary, so there is no wrap or overshoot.
//   Reset mid-operation: all state returns to reset values immediately, and a
//     pending update is discarded.
// TESTING (BASE_COUNT=2, NUM_CH=2, RESET_EN=1)
//   Release reset -> both clk_out rise at cycle 2, fall at cycle 4, period 4.
//   Write ch1 sel=1 mid-high-phase -> pending[1]=1, cfg_ready=0 for ch1.
//     At the next boundary sel_out[5:3]=1, then period 8; ch0 period stays 4.
//   Write ch0 en=0 -> clk_out[0] falls at the boundary and stays 0.
//     Then write en=1 sel=7 -> applied next cycle; first rise 256 cycles later.
//   Write cfg_ch=5 -> accepted (cfg_ready=1), cfg_err pulses 1 cycle, no state change.
//   Write issued on the exact boundary cycle -> applied one full period later.
//   Assert reset while pending=1 -> clk_out=0, sel_out=0, pending=0 the same cycle.

Source files
------------

// File: rtl/dcm_multi_if.sv
// Config handshake and divided-clock outputs of the multi-channel divider.
interface dcm_multi_if #(
    parameter int NUM_CH = 2
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [2:0]            cfg_ch;
    logic [2:0]            cfg_sel;
    logic                  cfg_en;
    logic                  cfg_err;
    logic [NUM_CH-1:0]     clk_out;
    logic [3*NUM_CH-1:0]   sel_out;
    logic [NUM_CH-1:0]     pending;

    modport master (
        output cfg_valid, cfg_ch, cfg_sel, cfg_en,
        input  cfg_ready, cfg_err, clk_out, sel_out, pending
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_sel, cfg_en,
        output cfg_ready, cfg_err, clk_out, sel_out, pending
    );
endinterface

// File: rtl/dcm_multi.sv
// Multi-channel programmable clock divider with glitch-free, boundary-aligned
// rate/enable updates delivered through a valid/ready config port.

// One divider channel: counter, output toggle and a single-entry shadow
// register that is applied at the falling edge of the output (or at once
// when the channel is stopped).
module dcm_multi_ch #(
    parameter int BASE_COUNT = 5_000_000,
    parameter int CNT_W      = 30,
    parameter int RESET_EN   = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr,
    input  logic [2:0] wr_sel,
    input  logic       wr_en,
    output logic       clk_out,
    output logic [2:0] sel_out,
    output logic       pending
);
    localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_COUNT);

    // Half-period for a rate select; multiplier table 1,2,4,10,16,32,64,128.
    function automatic logic [CNT_W-1:0] half_of(input logic [2:0] sel);
        case (sel)
            3'd0:    return BASE;
            3'd1:    return BASE << 1;
            3'd2:    return BASE << 2;
            3'd3:    return BASE * CNT_W'(10);
            3'd4:    return BASE << 4;
            3'd5:    return BASE << 5;
            3'd6:    return BASE << 6;
            default: return BASE << 7;
        endcase
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic [2:0]       sel_q, sel_d;
    logic             en_q, en_d;
    logic             pend_q, pend_d;
    logic [2:0]       sh_sel_q, sh_sel_d;
    logic             sh_en_q, sh_en_d;

    logic [CNT_W-1:0] half_m1;
    logic             at_top;
    logic             boundary;

    // Half-period always comes from the active select, so a shadowed rate
    // change cannot make the running count overshoot.
    assign half_m1  = half_of(sel_q) - CNT_W'(1);
    assign at_top   = (cnt_q == half_m1);
    assign boundary = en_q & at_top & clk_q;

    // Next-state: count/toggle, then shadow apply, then capture of a new write.
    always_comb begin
        cnt_d    = cnt_q;
        clk_d    = clk_q;
        sel_d    = sel_q;
        en_d     = en_q;
        pend_d   = pend_q;
        sh_sel_d = sh_sel_q;
        sh_en_d  = sh_en_q;

        if (en_q) begin
            if (at_top) begin
                cnt_d = '0;
                clk_d = ~clk_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
            clk_d = 1'b0;
        end

        // Only an update that was already pending before this cycle applies;
        // a write landing on the boundary waits for the next one.
        if (pend_q && (boundary || !en_q)) begin
            sel_d  = sh_sel_q;
            en_d   = sh_en_q;
            cnt_d  = '0;
            clk_d  = 1'b0;
            pend_d = 1'b0;
        end

        if (wr) begin
            sh_sel_d = wr_sel;
            sh_en_d  = wr_en;
            pend_d   = 1'b1;
        end
    end

    // Channel state registers; reset discards any pending update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            clk_q    <= 1'b0;
            sel_q    <= 3'd0;
            en_q     <= 1'(RESET_EN);
            pend_q   <= 1'b0;
            sh_sel_q <= 3'd0;
            sh_en_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            clk_q    <= clk_d;
            sel_q    <= sel_d;
            en_q     <= en_d;
            pend_q   <= pend_d;
            sh_sel_q <= sh_sel_d;
            sh_en_q  <= sh_en_d;
        end
    end

    assign clk_out = clk_q;
    assign sel_out = sel_q;
    assign pending = pend_q;
endmodule

// Top: config decode, error pulse and the channel array.
module dcm_multi #(
    parameter int NUM_CH     = 2,
    parameter int BASE_COUNT = 5_000_000,
    parameter int CNT_W      = 30,
    parameter int RESET_EN   = 1
) (
    input  logic         clock,
    input  logic         reset,
    dcm_multi_if.slave   bus
);
    logic [7:0]          ch_ok;
    logic [7:0]          pend_pad;
    logic                accept;
    logic                err_q, err_d;
    logic [NUM_CH-1:0]   clk_vec;
    logic [NUM_CH-1:0]   pend_vec;
    logic [3*NUM_CH-1:0] sel_vec;

    // Channel indices beyond NUM_CH are always ready so a bad write drains.
    assign ch_ok         = 8'((1 << NUM_CH) - 1);
    assign pend_pad      = 8'(pend_vec);
    assign bus.cfg_ready = ~ch_ok[bus.cfg_ch] | ~pend_pad[bus.cfg_ch];
    assign accept        = bus.cfg_valid & bus.cfg_ready;

    // Error pulse for an accepted write to a nonexistent channel.
    always_comb begin
        err_d = accept & ~ch_ok[bus.cfg_ch];
    end

    // Error pulse register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr;
        assign wr = accept & (bus.cfg_ch == 3'(i));

        dcm_multi_ch #(
            .BASE_COUNT (BASE_COUNT),
            .CNT_W      (CNT_W),
            .RESET_EN   (RESET_EN)
        ) u_ch (
            .clock   (clock),
            .reset   (reset),
            .wr      (wr),
            .wr_sel  (bus.cfg_sel),
            .wr_en   (bus.cfg_en),
            .clk_out (clk_vec[i]),
            .sel_out (sel_vec[3*i +: 3]),
            .pending (pend_vec[i])
        );
    end

    assign bus.cfg_err = err_q;
    assign bus.clk_out = clk_vec;
    assign bus.sel_out = sel_vec;
    assign bus.pending = pend_vec;
endmodule

// File: tb/tb_dcm_multi.sv
// Bench for dcm_multi: directed scenarios plus random config traffic, all
// checked against a phase-position model of each channel.
module tb_dcm_multi;
    localparam int NUM_CH = 2;
    localparam int BASE   = 2;
    localparam int OBS_W  = 5*NUM_CH + 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    dcm_multi_if #(.NUM_CH(NUM_CH)) ifc();

    dcm_multi #(
        .NUM_CH(NUM_CH), .BASE_COUNT(BASE), .CNT_W(12), .RESET_EN(1)
    ) dut (
        .clock(clock), .reset(reset), .bus(ifc)
    );

    always #5 clock = ~clock;

    // Reference model: each channel is a position within its full period;
    // output is high in the second half of the period.
    int unsigned mult [8] = '{1, 2, 4, 10, 16, 32, 64, 128};
    bit m_en     [NUM_CH];
    int m_sel    [NUM_CH];
    int m_pos    [NUM_CH];
    bit m_pend   [NUM_CH];
    int m_sh_sel [NUM_CH];
    bit m_sh_en  [NUM_CH];
    bit m_err;

    function automatic int half(int c);
        return BASE * int'(mult[m_sel[c]]);
    endfunction

    function automatic bit m_ready(int ch);
        if (ch >= NUM_CH) return 1'b1;
        return !m_pend[ch];
    endfunction

    function automatic logic [OBS_W-1:0] exp_obs();
        logic [NUM_CH-1:0]   c;
        logic [3*NUM_CH-1:0] s;
        logic [NUM_CH-1:0]   p;
        for (int k = 0; k < NUM_CH; k++) begin
            c[k]        = m_en[k] && (m_pos[k] >= half(k));
            s[3*k +: 3] = 3'(m_sel[k]);
            p[k]        = m_pend[k];
        end
        return {c, s, p, m_err, m_ready(int'(ifc.cfg_ch))};
    endfunction

    function automatic logic [OBS_W-1:0] obs();
        return {ifc.clk_out, ifc.sel_out, ifc.pending, ifc.cfg_err, ifc.cfg_ready};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_en[k] = 1'b1; m_sel[k] = 0; m_pos[k] = 0;
            m_pend[k] = 1'b0; m_sh_sel[k] = 0; m_sh_en[k] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then
    // return at the falling edge where outputs are sampled.
    task automatic step();
        int ch, period;
        bit acc, bnd;
        @(posedge clock);
        ch  = int'(ifc.cfg_ch);
        acc = ifc.cfg_valid && m_ready(ch);
        for (int k = 0; k < NUM_CH; k++) begin
            period = 2 * half(k);
            bnd    = m_en[k] && (m_pos[k] == period - 1);
            if (m_pend[k] && (bnd || !m_en[k])) begin
                m_sel[k] = m_sh_sel[k]; m_en[k] = m_sh_en[k];
                m_pos[k] = 0; m_pend[k] = 1'b0;
            end else if (m_en[k]) begin
                m_pos[k] = (m_pos[k] + 1) % period;
            end else begin
                m_pos[k] = 0;
            end
        end
        if (acc && ch < NUM_CH) begin
            m_sh_sel[ch] = int'(ifc.cfg_sel);
            m_sh_en[ch]  = ifc.cfg_en;
            m_pend[ch]   = 1'b1;
        end
        m_err = acc && (ch >= NUM_CH);
        @(negedge clock);
    endtask

    task automatic write(int ch, int sel, bit en);
        ifc.cfg_valid = 1'b1;
        ifc.cfg_ch    = 3'(ch);
        ifc.cfg_sel   = 3'(sel);
        ifc.cfg_en    = en;
        step();
        ifc.cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [NUM_CH-1:0] exp_c;
        reset = 1'b1;
        ifc.cfg_valid = 1'b0; ifc.cfg_ch = 3'd0; ifc.cfg_sel = 3'd0; ifc.cfg_en = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        if ({ifc.clk_out, ifc.sel_out, ifc.pending, ifc.cfg_err} !== '0) begin
            errors++;
            $display("FAIL reset_state got %h exp 0", {ifc.clk_out, ifc.sel_out, ifc.pending, ifc.cfg_err});
        end
        checks++;
        reset = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            step();
            exp_c = ((cyc / 2) % 2) ? '1 : '0;
            if (ifc.clk_out !== exp_c) begin
                errors++;
                $display("FAIL first_edges cyc %0d got %b exp %b", cyc, ifc.clk_out, exp_c);
            end
            checks++;
            if (obs() !== exp_obs()) begin
                errors++;
                $display("FAIL reset_run cyc %0d got %h exp %h", cyc, obs(), exp_obs());
            end
            checks++;
        end
    endtask

    task automatic test_rate_change();
        int t0 = -1, t1 = -1, p0 = 0, p1 = 0;
        logic [NUM_CH-1:0] prev;
        for (int i = 0; i < 20 && !(m_pos[1] >= half(1) && m_pos[1] < 2*half(1) - 1); i++) step();
        write(1, 1, 1'b1);
        if (ifc.pending[1] !== 1'b1 || ifc.cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL rate_pending got pend %b ready %b exp 1 0", ifc.pending[1], ifc.cfg_ready);
        end
        checks++;
        prev = ifc.clk_out;
        for (int cyc = 0; cyc < 40; cyc++) begin
            step();
            if (obs() !== exp_obs()) begin
                errors++;
                $display("FAIL rate_run cyc %0d got %h exp %h", cyc, obs(), exp_obs());
            end
            checks++;
            if (ifc.clk_out[0] && !prev[0]) begin if (t0 >= 0) p0 = cyc - t0; t0 = cyc; end
            if (ifc.clk_out[1] && !prev[1]) begin if (t1 >= 0) p1 = cyc - t1; t1 = cyc; end
            prev = ifc.clk_out;
        end
        if (p0 != 4 || p1 != 8 || ifc.sel_out[5:3] !== 3'd1) begin
            errors++;
            $display("FAIL rate_period got p0 %0d p1 %0d sel1 %0d exp 4 8 1", p0, p1, ifc.sel_out[5:3]);
        end
        checks++;
    endtask

    task automatic test_bad_channel();
        ifc.cfg_valid = 1'b1; ifc.cfg_ch = 3'd5; ifc.cfg_sel = 3'd6; ifc.cfg_en = 1'b0;
        #1;
        if (ifc.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL bad_ready got %b exp 1", ifc.cfg_ready);
        end
        checks++;
        step();
        ifc.cfg_valid = 1'b0;
        if (ifc.cfg_err !== 1'b1 || obs() !== exp_obs()) begin
            errors++;
            $display("FAIL bad_err_pulse got err %b obs %h exp 1 %h", ifc.cfg_err, obs(), exp_obs());
        end
        checks++;
        step();
        if (ifc.cfg_err !== 1'b0 || obs() !== exp_obs()) begin
            errors++;
            $display("FAIL bad_err_clear got err %b obs %h exp 0 %h", ifc.cfg_err, obs(), exp_obs());
        end
        checks++;
    endtask

    task automatic test_boundary_write();
        for (int i = 0; i < 20 && m_pos[0] != 2*half(0) - 1; i++) step();
        write(0, 2, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step();
            if ((k < 4 && (ifc.pending[0] !== 1'b1 || ifc.sel_out[2:0] !== 3'd0)) ||
                (k == 4 && (ifc.pending[0] !== 1'b0 || ifc.sel_out[2:0] !== 3'd2))) begin
                errors++;
                $display("FAIL boundary_wait k %0d got pend %b sel %0d", k, ifc.pending[0], ifc.sel_out[2:0]);
            end
            checks++;
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            step();
            if (obs() !== exp_obs()) begin
                errors++;
                $display("FAIL boundary_run cyc %0d got %h exp %h", cyc, obs(), exp_obs());
            end
            checks++;
        end
    endtask

    task automatic test_disable_enable();
        int n = 0;
        write(0, 2, 1'b0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            step();
            if (obs() !== exp_obs()) begin
                errors++;
                $display("FAIL disable_run cyc %0d got %h exp %h", cyc, obs(), exp_obs());
            end
            checks++;
        end
        for (int cyc = 0; cyc < 16; cyc++) begin
            step();
            if (ifc.clk_out[0] !== 1'b0) begin
                errors++;
                $display("FAIL disable_hold cyc %0d got %b exp 0", cyc, ifc.clk_out[0]);
            end
            checks++;
        end
        write(0, 7, 1'b1);
        step();
        if (ifc.pending[0] !== 1'b0 || ifc.sel_out[2:0] !== 3'd7) begin
            errors++;
            $display("FAIL enable_apply got pend %b sel %0d exp 0 7", ifc.pending[0], ifc.sel_out[2:0]);
        end
        checks++;
        for (n = 1; n <= 300; n++) begin
            step();
            if (ifc.clk_out[0]) break;
        end
        if (n != 256) begin
            errors++;
            $display("FAIL enable_first_rise got %0d exp 256", n);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 20 && (m_pend[1] || m_pos[1] == 2*half(1) - 1); i++) step();
        write(1, 3, 1'b1);
        if (ifc.pending[1] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup got pend %b exp 1", ifc.pending[1]);
        end
        checks++;
        #2 reset = 1'b1;
        #1;
        if ({ifc.clk_out, ifc.sel_out, ifc.pending, ifc.cfg_err} !== '0) begin
            errors++;
            $display("FAIL midreset_clear got %h exp 0", {ifc.clk_out, ifc.sel_out, ifc.pending, ifc.cfg_err});
        end
        checks++;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            step();
            if (obs() !== exp_obs()) begin
                errors++;
                $display("FAIL midreset_run cyc %0d got %h exp %h", cyc, obs(), exp_obs());
            end
            checks++;
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ifc.cfg_valid = 1'($urandom % 2);
            ifc.cfg_ch    = 3'($urandom_range(0, 3));
            ifc.cfg_sel   = ($urandom % 4 != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            ifc.cfg_en    = ($urandom % 4) != 0;
            step();
            if (obs() !== exp_obs()) begin
                errors++;
                $display("FAIL random cyc %0d got %h exp %h", cyc, obs(), exp_obs());
            end
            checks++;
        end
        ifc.cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rate_change();
        test_bad_channel();
        test_boundary_write();
        test_disable_enable();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
